// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the I2S transceiver control path.
//   frame_size_t : selects a 16-bit or a 32-bit serial word per frame
//   ser_state_t  : transmit serializer states
//   F16_LEN/F32_LEN and frame_len() give the bit count for each frame size
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [0:0] {
        f16bits = 1'b0,
        f32bits = 1'b1
    } frame_size_t;

    localparam int F16_LEN = 16;
    localparam int F32_LEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } ser_state_t;

    // Number of data bits that a frame of the given size carries.
    function automatic int frame_len(input frame_size_t fs);
        int len;
        case (fs)
            f16bits: len = F16_LEN;
            f32bits: len = F32_LEN;
            default: len = F32_LEN;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ser_fifo_mem.sv
// ---------------------------------------------------------------------------
// ser_fifo_mem
// DEPTH-entry synchronous FIFO used as the transmit word buffer.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i, din_i    : write request and data (ignored while full)
//   pop_i            : read request (ignored while empty)
//   dout_o           : head word (valid while !empty_o)
//   level_o          : occupancy, 0..DEPTH
//   full_o, empty_o, almost_full_o : registered status derived from level
// ---------------------------------------------------------------------------
module ser_fifo_mem #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          din_i,
    output logic [DATA_W-1:0]          dout_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Accept/reject decisions use the pre-cycle status, so a push while
    // full is refused even when a pop happens in the same cycle.
    always_comb begin
        push_ok_s = push_i && !full_q;
        pop_ok_s  = pop_i && !empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + ONE_L;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + ONE_L;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + ONE_L;
            2'b01:   level_d = level_q - ONE_L;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == DEPTH_L);
        empty_d = (level_d == '0);
        af_d    = (level_d >= AF_L);
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o        = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o       = level_q;
    assign full_o        = full_q;
    assign empty_o       = empty_q;
    assign almost_full_o = af_q;

endmodule

// File: rtl/i2s_ser_tx_fifo.sv
// ---------------------------------------------------------------------------
// i2s_ser_tx_fifo
// I2S transmit buffer: parallel words are queued in a FIFO and one word per
// frame is shifted out MSB first on bit-clock strobes, followed by zero pad.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, wr_data    : push interface
//   frame_size        : f16bits / f32bits, latched at each frame start
//   bit_en            : one-clk strobe per serial bit period
//   frame_start       : WS edge, honoured only together with bit_en
//   clr_flags         : clears overflow/underrun
//   sd_out            : registered serial data
//   full, empty, almost_full, level : FIFO status
//   overflow, underrun: sticky error flags
// Build option:
//   I2S_PHILIPS_DELAY_EN defined  -> Philips timing, MSB one bit after WS edge
//   I2S_PHILIPS_DELAY_EN undefined -> left-justified, MSB on the WS-edge bit
// DATA_W must be at least 32 so that a 32-bit frame fits in one word.
// ---------------------------------------------------------------------------
module i2s_ser_tx_fifo
    import ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  frame_size_t            frame_size,
    input  logic                   bit_en,
    input  logic                   frame_start,
    input  logic                   clr_flags,
    output logic                   sd_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underrun
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] head_s;
    logic              full_s;
    logic              empty_s;
    logic              qual_start_s;
    logic              load_msb_s;
    logic              cur_msb_s;
    int                load_len_s;

    ser_state_t        state_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] shreg_q;
    frame_size_t       size_q;
    logic              sd_out_q;
    logic              overflow_q;
    logic              underrun_q;

    ser_fifo_mem #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_THRESH(AF_THRESH)
    ) u_mem (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (wr_en),
        .pop_i        (qual_start_s),
        .din_i        (wr_data),
        .dout_o       (head_s),
        .level_o      (level),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .almost_full_o(almost_full)
    );

    // Frame start qualification and MSB taps. The shift register keeps the
    // raw word and shifts left, so the MSB of the current frame is always
    // bit L-1 of the register; bits above L-1 are never tapped.
    always_comb begin
        qual_start_s = frame_start && bit_en;
        load_len_s   = frame_len(frame_size);
        if (frame_size == f16bits) begin
            load_msb_s = head_s[F16_LEN-1];
        end else begin
            load_msb_s = head_s[F32_LEN-1];
        end
        if (size_q == f16bits) begin
            cur_msb_s = shreg_q[F16_LEN-1];
        end else begin
            cur_msb_s = shreg_q[F32_LEN-1];
        end
    end

    // Serializer FSM: frame start (re)loads from the FIFO head, each bit_en
    // advances one bit, and PAD holds the line low until the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            size_q    <= f32bits;
            sd_out_q  <= 1'b0;
        end else if (qual_start_s) begin
            if (!empty_s) begin
                size_q  <= frame_size;
                state_q <= SHIFT;
`ifdef I2S_PHILIPS_DELAY_EN
                // One-bit delay: the WS-edge bit is a zero, MSB follows.
                sd_out_q  <= 1'b0;
                shreg_q   <= head_s;
                bit_cnt_q <= CW'(load_len_s);
`else
                sd_out_q  <= load_msb_s;
                shreg_q   <= head_s << 1;
                bit_cnt_q <= CW'(load_len_s - 1);
`endif
            end else begin
                // Void frame: nothing to send, keep the line low all frame.
                state_q   <= PAD;
                sd_out_q  <= 1'b0;
                shreg_q   <= '0;
                bit_cnt_q <= '0;
            end
        end else if (bit_en) begin
            case (state_q)
                SHIFT: begin
                    if (bit_cnt_q == '0) begin
                        state_q  <= PAD;
                        sd_out_q <= 1'b0;
                    end else begin
                        sd_out_q  <= cur_msb_s;
                        shreg_q   <= shreg_q << 1;
                        bit_cnt_q <= bit_cnt_q - CW'(1);
                    end
                end
                PAD: begin
                    sd_out_q <= 1'b0;
                end
                IDLE: begin
                    sd_out_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    sd_out_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a set event in the same cycle beats clr_flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (wr_en && full_s) begin
                overflow_q <= 1'b1;
            end else if (clr_flags) begin
                overflow_q <= 1'b0;
            end
            if (qual_start_s && empty_s) begin
                underrun_q <= 1'b1;
            end else if (clr_flags) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign sd_out   = sd_out_q;
    assign full     = full_s;
    assign empty    = empty_s;
    assign overflow = overflow_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_ser_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_i2s_ser_tx_fifo
// Self-checking bench for i2s_ser_tx_fifo. A queue model of the FIFO tracks
// stored words; at every frame start the expected serial bit stream for the
// frame is pushed onto a scoreboard and popped at each bit strobe.
// ---------------------------------------------------------------------------
module tb_i2s_ser_tx_fifo;
    import ctrl_pkg::*;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int AF_THRESH = 6;
`ifdef I2S_PHILIPS_DELAY_EN
    localparam int PD = 1;
`else
    localparam int PD = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    frame_size_t       frame_size;
    logic              bit_en;
    logic              frame_start;
    logic              clr_flags;
    logic              sd_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [3:0]        level;
    logic              overflow;
    logic              underrun;

    i2s_ser_tx_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_THRESH(AF_THRESH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .frame_size (frame_size),
        .bit_en     (bit_en),
        .frame_start(frame_start),
        .clr_flags  (clr_flags),
        .sd_out     (sd_out),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .level      (level),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] mdl_q[$];
    logic        exp_q[$];
    logic        exp_ovf = 1'b0;
    logic        exp_unr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check_val({tag, " level"}, 32'(level), 32'(mdl_q.size()));
        check_val({tag, " full"}, 32'(full), 32'(mdl_q.size() == DEPTH));
        check_val({tag, " empty"}, 32'(empty), 32'(mdl_q.size() == 0));
        check_val({tag, " almost_full"}, 32'(almost_full), 32'(mdl_q.size() >= AF_THRESH));
        check_val({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        check_val({tag, " underrun"}, 32'(underrun), 32'(exp_unr));
    endtask

    task automatic push_word(input logic [31:0] d);
        bit pre_full;
        pre_full = (mdl_q.size() == DEPTH);
        wr_en    = 1'b1;
        wr_data  = d;
        tick();
        wr_en = 1'b0;
        if (pre_full) exp_ovf = 1'b1;
        else mdl_q.push_back(d);
        check_status("push");
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        exp_ovf = 1'b0;
        exp_unr = 1'b0;
        check_status("clr");
    endtask

    // One frame of nb bit strobes, the first carrying frame_start. Bit
    // strobes are separated by an idle clock on which sd_out must hold.
    task automatic do_frame(input frame_size_t fsz, input int nb,
                            input logic with_push, input logic [31:0] pdata);
        logic [31:0] w;
        int          len;
        int          idx;
        bit          pre_empty;
        bit          pre_full;
        logic        e;
        logic        last;
        w         = 32'h0;
        len       = (fsz == f16bits) ? 16 : 32;
        pre_empty = (mdl_q.size() == 0);
        pre_full  = (mdl_q.size() == DEPTH);
        if (!pre_empty) w = mdl_q.pop_front();
        else exp_unr = 1'b1;
        if (with_push) begin
            if (pre_full) exp_ovf = 1'b1;
            else mdl_q.push_back(pdata);
        end
        for (int k = 0; k < nb; k++) begin
            idx = k - PD;
            if (pre_empty || idx < 0 || idx >= len) e = 1'b0;
            else e = w[len - 1 - idx];
            exp_q.push_back(e);
        end
        frame_start = 1'b1;
        bit_en      = 1'b1;
        frame_size  = fsz;
        wr_en       = with_push;
        wr_data     = pdata;
        tick();
        frame_start = 1'b0;
        bit_en      = 1'b0;
        wr_en       = 1'b0;
        // A size change after the frame start must not affect this frame.
        frame_size  = (fsz == f16bits) ? f32bits : f16bits;
        last = exp_q.pop_front();
        check_val("sd_out bit0", 32'(sd_out), 32'(last));
        check_status("frame start");
        for (int k = 1; k < nb; k++) begin
            tick();
            check_val("sd_out hold", 32'(sd_out), 32'(last));
            bit_en = 1'b1;
            tick();
            bit_en = 1'b0;
            e = exp_q.pop_front();
            check_val("sd_out bit", 32'(sd_out), 32'(e));
            last = e;
        end
    endtask

    initial begin
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = '0;
        frame_size  = f32bits;
        bit_en      = 1'b0;
        frame_start = 1'b0;
        clr_flags   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_val("reset sd_out", 32'(sd_out), 32'h0);
        check_status("reset");

        // Basic 32-bit frame followed by pad zeros.
        push_word(32'hA5A5_0F0F);
        do_frame(f32bits, 34, 1'b0, 32'h0);

        // 16-bit frame: only the low half is sent.
        push_word(32'h1234_8001);
        do_frame(f16bits, 19, 1'b0, 32'h0);

        // Fill past full: 8 accepted, the 9th overflows.
        for (int i = 0; i < 9; i++) push_word(32'hC0DE_0000 + 32'(i));
        clear_flags();

        // Push and pop together while full: push rejected, pop proceeds.
        do_frame(f32bits, 34, 1'b1, 32'hDEAD_BEEF);
        clear_flags();

        // Keep refilling while popping to carry the pointers across the wrap.
        for (int i = 0; i < 8; i++) begin
            push_word($urandom);
            do_frame(($urandom_range(0, 1) == 0) ? f16bits : f32bits, 34, 1'b0, 32'h0);
        end
        while (mdl_q.size() > 0) do_frame(f16bits, 18, 1'b0, 32'h0);

        // Frame start while empty with a same-cycle push.
        do_frame(f32bits, 33, 1'b1, 32'h5A5A_F00D);
        clear_flags();

        // Reset partway through a frame.
        do_frame(f32bits, 10, 1'b0, 32'h0);
        push_word(32'hFFFF_FFFF);
        do_frame(f32bits, 10, 1'b0, 32'h0);
        rst    = 1'b1;
        bit_en = 1'b1;
        tick();
        rst    = 1'b0;
        bit_en = 1'b0;
        mdl_q.delete();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_unr = 1'b0;
        check_val("mid-frame reset sd_out", 32'(sd_out), 32'h0);
        check_status("mid-frame reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_ser_tx_fifo.md
Name: i2s_ser_tx_fifo

Overview:
- Single-clock, parametrised transmit buffer for the I2S transceiver.
- Accepts parallel audio words from the register/bus side into a DEPTH-entry FIFO.
- Serialises one word per I2S frame onto the serial data line, MSB first, on bit-clock strobes.
- Adds over the previous generation: occupancy level, almost-full threshold, sticky overflow/underrun flags, per-frame latching of the frame size, and zero padding after the last data bit.

Parameters:
- DATA_W, 32, width of a FIFO word; the maximum frame length in bits.
- DEPTH, 8, number of FIFO entries; must be a power of 2 and ≥ 2.
- AF_THRESH, 6, almost_full asserts when level ≥ AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push request.
- wr_data  in  DATA_W  word to push.
- frame_size  in  frame_size_t (ctrl_pkg)  f16bits or f32bits.
- bit_en  in  1  one-clk strobe per serial bit period.
- frame_start  in  1  word-boundary strobe (WS edge); qualified only when bit_en is also high.
- clr_flags  in  1  clears the sticky flags.
- sd_out  out  1  serial data, registered.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_THRESH.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a push was attempted while full.
- underrun  out  1  sticky: a frame started while empty.

Behaviour:
- Reset: sets pointers = 0, level = 0, sd_out = 0, overflow = 0, underrun = 0, serializer idle, bit_cnt = 0, latched size = f32bits. Resulting outputs: empty = 1, full = 0, almost_full = 0. Reset mid-frame aborts the frame immediately and discards all stored data.
- Push: wr_en && !full writes mem[wr_ptr] and increments wr_ptr.
  - wr_en && full drops the data and sets overflow the next clk.
  - full is evaluated before any same-cycle pop, so a push while full is always rejected.
- Pointers: $clog2(DEPTH)+1 bits each; the extra MSB distinguishes full from empty; wrap-around is natural.
- Pop: occurs only on a qualified frame start (frame_start && bit_en).
  - If !empty: the head word is loaded into the shift register, rd_ptr increments, and the size is latched from frame_size.
  - If empty: underrun is set, the frame is marked void, and sd_out = 0 for the whole frame.
- Level: +1 on push only, −1 on pop only, unchanged when both or neither occur. A same-cycle push and pop while empty: the push lands, the pop fails, underrun is set.
- Serializer states: IDLE, SHIFT, PAD.
  - IDLE → SHIFT on a qualified frame start with data. sd_out <= word[L−1] (L = 16 or 32 per latched size); bit_cnt <= L−1.
  - SHIFT: each bit_en drives the next lower bit to sd_out and decrements bit_cnt. When bit_cnt == 0, the next bit_en moves to PAD with sd_out <= 0.
  - PAD: sd_out = 0 until the next qualified frame start.
  - From any state, a qualified frame start restarts the sequence. A frame cut short by an early frame_start truncates the word; no error is flagged.
- 16-bit frames: use wr_data[15:0]; bits [DATA_W−1:16] are ignored. A frame_size change mid-frame has no effect until the next frame start.
- Timing: sd_out changes only on clk edges where bit_en = 1. Latency from a qualified frame start to the first data bit on sd_out is 1 clk.
- Flags: clr_flags clears overflow/underrun the next clk; a same-cycle set event wins over the clear.

Optional Feature:
- Macro: I2S_PHILIPS_DELAY_EN.
- Defined: Philips one-bit delay. The qualified frame start still pops and latches, but sd_out <= 0 for that bit. The MSB appears on the following bit_en, and PAD is entered one bit later.
- Undefined: left-justified timing, with the MSB driven on the frame-start bit as above.

Decomposition:
- ctrl_pkg (existing) keeps the frame_size_t enum (f16bits, f32bits).
- Add to ctrl_pkg: localparams F16_LEN = 16 and F32_LEN = 32, and the ser_state_t enum {IDLE, SHIFT, PAD}.
- Sub-module ser_fifo_mem: storage array, pointers, level, full/empty/almost_full. Interface: push, pop, din, dout, level.
- The top level holds the serializer FSM and the sticky flags.

Test Plan:
- Reset, push 0xA5A5_0F0F, frame_size = f32bits, qualified frame start, then 32 bit_en → sd_out = 1,0,1,0,0,1,0,1,… ending 1; then 0 in PAD; level returns 1 → 0.
- frame_size = f16bits, push 0x1234_8001 → sd_out = 1,0,…,0,1 (16 bits), then PAD zeros; upper half never appears.
- DEPTH = 8, push 9 words without popping → full = 1 after the 8th push, overflow = 1 after the 9th, level = 8, almost_full = 1 from the 6th push; clr_flags → overflow = 0.
- Empty FIFO, qualified frame start → underrun = 1, sd_out = 0 for 32 bits; a push in the same cycle gives level = 1.
- Level 8 (full), push and pop in the same cycle → push rejected, overflow = 1, level = 7. Then push 8 more words with pops to cross the pointer wrap → data order is preserved.
- Assert rst at bit 10 of a 32-bit frame → sd_out = 0 and level = 0 next clk, empty = 1. With I2S_PHILIPS_DELAY_EN, repeat the first scenario → first bit 0, MSB on the 2nd bit_en.
